// File: rtl/afu_req_arbiter.sv
// Two-requester arbiter for a shared CCI-style read/write request channel pair.
// Define ARB_STRICT_PRIO_EN for fixed priority (requester 0 first); default is round-robin.
module afu_req_arbiter #(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*ADDR_LMT-1:0]    u_rd_req_addr,
  input  logic [2*MDATA-1:0]       u_rd_req_mdata,
  input  logic [1:0]               u_rd_req_en,
  output logic [1:0]               u_rd_req_almostfull,
  output logic [1:0]               u_rd_rsp_valid,
  output logic [MDATA-1:0]         u_rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0]   u_rd_rsp_data,
  input  logic [2*ADDR_LMT-1:0]    u_wr_req_addr,
  input  logic [2*MDATA-1:0]       u_wr_req_mdata,
  input  logic [2*CACHE_WIDTH-1:0] u_wr_req_data,
  input  logic [1:0]               u_wr_req_en,
  output logic [1:0]               u_wr_req_almostfull,
  output logic [1:0]               u_wr_rsp0_valid,
  output logic [1:0]               u_wr_rsp1_valid,
  output logic [MDATA-1:0]         u_wr_rsp0_mdata,
  output logic [MDATA-1:0]         u_wr_rsp1_mdata,
  output logic [ADDR_LMT-1:0]      rd_req_addr,
  output logic [MDATA-1:0]         rd_req_mdata,
  output logic                     rd_req_en,
  input  logic                     rd_req_almostfull,
  input  logic                     rd_rsp_valid,
  input  logic [MDATA-1:0]         rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0]   rd_rsp_data,
  output logic [ADDR_LMT-1:0]      wr_req_addr,
  output logic [MDATA-1:0]         wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]   wr_req_data,
  output logic                     wr_req_en,
  input  logic                     wr_req_almostfull,
  input  logic                     wr_rsp0_valid,
  input  logic [MDATA-1:0]         wr_rsp0_mdata,
  input  logic                     wr_rsp1_valid,
  input  logic [MDATA-1:0]         wr_rsp1_mdata,
  output logic [1:0]               proto_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [ADDR_LMT-1:0]    rd_hold_addr  [2];
  logic [MDATA-2:0]       rd_hold_mdata [2];
  logic [ADDR_LMT-1:0]    wr_hold_addr  [2];
  logic [MDATA-2:0]       wr_hold_mdata [2];
  logic [CACHE_WIDTH-1:0] wr_hold_data  [2];

  logic [1:0] rd_cand, wr_cand;
  logic [1:0] rd_gnt, wr_gnt;
  logic [1:0] rd_rsp_hit, wr_rsp0_hit, wr_rsp1_hit;
  logic [1:0] proto_viol;

  logic [CNT_W-1:0] rd_cnt_reg [2];
  logic [CNT_W-1:0] rd_cnt_next [2];
  logic [CNT_W-1:0] wr_cnt_reg [2];
  logic [CNT_W-1:0] wr_cnt_next [2];

  // Response routing is purely combinational on the mdata MSB tag.
  assign u_rd_rsp_valid  = rd_rsp_hit;
  assign u_rd_rsp_mdata  = {1'b0, rd_rsp_mdata[MDATA-2:0]};
  assign u_rd_rsp_data   = rd_rsp_data;
  assign u_wr_rsp0_valid = wr_rsp0_hit;
  assign u_wr_rsp1_valid = wr_rsp1_hit;
  assign u_wr_rsp0_mdata = {1'b0, wr_rsp0_mdata[MDATA-2:0]};
  assign u_wr_rsp1_mdata = {1'b0, wr_rsp1_mdata[MDATA-2:0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic                   rd_valid_reg, wr_valid_reg;
    logic [ADDR_LMT-1:0]    rd_addr_reg, wr_addr_reg;
    logic [MDATA-2:0]       rd_mdata_reg, wr_mdata_reg;
    logic [CACHE_WIDTH-1:0] wr_data_reg;
    logic                   rd_load, wr_load;
    logic [CNT_W:0]         rd_sum, rd_dec, wr_sum, wr_dec;
    logic                   unused_mdata_msb;

    assign rd_rsp_hit[gi]  = rd_rsp_valid  & (rd_rsp_mdata[MDATA-1]  == 1'(gi));
    assign wr_rsp0_hit[gi] = wr_rsp0_valid & (wr_rsp0_mdata[MDATA-1] == 1'(gi));
    assign wr_rsp1_hit[gi] = wr_rsp1_valid & (wr_rsp1_mdata[MDATA-1] == 1'(gi));

    assign u_rd_req_almostfull[gi] = rd_valid_reg | (rd_cnt_reg[gi] == MAX_CNT);
    assign u_wr_req_almostfull[gi] = wr_valid_reg | (wr_cnt_reg[gi] == MAX_CNT);
    assign rd_cand[gi] = rd_valid_reg & (rd_cnt_reg[gi] < MAX_CNT);
    assign wr_cand[gi] = wr_valid_reg & (wr_cnt_reg[gi] < MAX_CNT);

    assign rd_load = u_rd_req_en[gi] & ~u_rd_req_almostfull[gi];
    assign wr_load = u_wr_req_en[gi] & ~u_wr_req_almostfull[gi];
    assign proto_viol[gi] = (u_rd_req_en[gi] & u_rd_req_almostfull[gi]) |
                            (u_wr_req_en[gi] & u_wr_req_almostfull[gi]);

    // The requester's own mdata MSB is replaced by its ID downstream.
    assign unused_mdata_msb = u_rd_req_mdata[gi*MDATA + MDATA-1] ^
                              u_wr_req_mdata[gi*MDATA + MDATA-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid_reg <= 1'b0;
        rd_addr_reg  <= '0;
        rd_mdata_reg <= '0;
        wr_valid_reg <= 1'b0;
        wr_addr_reg  <= '0;
        wr_mdata_reg <= '0;
        wr_data_reg  <= '0;
      end else begin
        if (rd_load) begin
          rd_valid_reg <= 1'b1;
          rd_addr_reg  <= u_rd_req_addr[gi*ADDR_LMT +: ADDR_LMT];
          rd_mdata_reg <= u_rd_req_mdata[gi*MDATA +: MDATA-1];
        end else if (rd_gnt[gi]) begin
          rd_valid_reg <= 1'b0;
        end
        if (wr_load) begin
          wr_valid_reg <= 1'b1;
          wr_addr_reg  <= u_wr_req_addr[gi*ADDR_LMT +: ADDR_LMT];
          wr_mdata_reg <= u_wr_req_mdata[gi*MDATA +: MDATA-1];
          wr_data_reg  <= u_wr_req_data[gi*CACHE_WIDTH +: CACHE_WIDTH];
        end else if (wr_gnt[gi]) begin
          wr_valid_reg <= 1'b0;
        end
      end
    end

    assign rd_hold_addr[gi]  = rd_addr_reg;
    assign rd_hold_mdata[gi] = rd_mdata_reg;
    assign wr_hold_addr[gi]  = wr_addr_reg;
    assign wr_hold_mdata[gi] = wr_mdata_reg;
    assign wr_hold_data[gi]  = wr_data_reg;

    // Add the grant first, then subtract responses with a floor at zero.
    assign rd_sum = {1'b0, rd_cnt_reg[gi]} + {{CNT_W{1'b0}}, rd_gnt[gi]};
    assign rd_dec = {{CNT_W{1'b0}}, rd_rsp_hit[gi]};
    assign rd_cnt_next[gi] = (rd_sum < rd_dec) ? '0 : CNT_W'(rd_sum - rd_dec);

    assign wr_sum = {1'b0, wr_cnt_reg[gi]} + {{CNT_W{1'b0}}, wr_gnt[gi]};
    assign wr_dec = {{(CNT_W-1){1'b0}}, wr_rsp0_hit[gi] & wr_rsp1_hit[gi],
                     wr_rsp0_hit[gi] ^ wr_rsp1_hit[gi]};
    assign wr_cnt_next[gi] = (wr_sum < wr_dec) ? '0 : CNT_W'(wr_sum - wr_dec);
  end

`ifdef ARB_STRICT_PRIO_EN
  function automatic logic [1:0] prio_pick(input logic [1:0] cand);
    prio_pick = cand[0] ? 2'b01 : {cand[1], 1'b0};
  endfunction

  assign rd_gnt = rd_req_almostfull ? 2'b00 : prio_pick(rd_cand);
  assign wr_gnt = wr_req_almostfull ? 2'b00 : prio_pick(wr_cand);
`else
  logic rd_last_reg, wr_last_reg;

  function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic last);
    case (cand)
      2'b11:   rr_pick = last ? 2'b01 : 2'b10;
      default: rr_pick = cand;
    endcase
  endfunction

  assign rd_gnt = rd_req_almostfull ? 2'b00 : rr_pick(rd_cand, rd_last_reg);
  assign wr_gnt = wr_req_almostfull ? 2'b00 : rr_pick(wr_cand, wr_last_reg);

  // Pointer starts at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_last_reg <= 1'b1;
      wr_last_reg <= 1'b1;
    end else begin
      if (|rd_gnt) rd_last_reg <= rd_gnt[1];
      if (|wr_gnt) wr_last_reg <= wr_gnt[1];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rd_cnt_reg[i] <= '0;
        wr_cnt_reg[i] <= '0;
      end
      proto_err <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rd_cnt_reg[i] <= rd_cnt_next[i];
        wr_cnt_reg[i] <= wr_cnt_next[i];
      end
      proto_err <= proto_err | proto_viol;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
    end else begin
      rd_req_en <= |rd_gnt;
      if (rd_gnt[1]) begin
        rd_req_addr  <= rd_hold_addr[1];
        rd_req_mdata <= {1'b1, rd_hold_mdata[1]};
      end else if (rd_gnt[0]) begin
        rd_req_addr  <= rd_hold_addr[0];
        rd_req_mdata <= {1'b0, rd_hold_mdata[0]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_en    <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_mdata <= '0;
      wr_req_data  <= '0;
    end else begin
      wr_req_en <= |wr_gnt;
      if (wr_gnt[1]) begin
        wr_req_addr  <= wr_hold_addr[1];
        wr_req_mdata <= {1'b1, wr_hold_mdata[1]};
        wr_req_data  <= wr_hold_data[1];
      end else if (wr_gnt[0]) begin
        wr_req_addr  <= wr_hold_addr[0];
        wr_req_mdata <= {1'b0, wr_hold_mdata[0]};
        wr_req_data  <= wr_hold_data[0];
      end
    end
  end

endmodule

// File: doc/afu_req_arbiter.md
Name: afu_req_arbiter

Overview:
- Shares one CCI-style read-request and write-request channel pair between two AFU user engines (requester 0 and 1).
- Sits between the AFU user instances and the single downstream request/response interface.
- Buffers one request per requester per channel and grants the downstream channel round-robin.
- Tags the mdata MSB with the requester ID and routes read and write responses back by that tag.

Parameters:
- ADDR_LMT, 20, request address width.
- MDATA, 14, mdata width. MSB is reserved for the requester ID.
- CACHE_WIDTH, 512, cache-line data width.
- MAX_OUTSTANDING, 16, per-requester limit on outstanding reads and on outstanding writes.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- u_rd_req_addr  in  2*ADDR_LMT  per-requester read address; requester i uses slice [i*ADDR_LMT +: ADDR_LMT]
- u_rd_req_mdata  in  2*MDATA  per-requester read mdata
- u_rd_req_en  in  2  per-requester read request strobe
- u_rd_req_almostfull  out  2  per-requester read back-pressure
- u_rd_rsp_valid  out  2  routed read response valid
- u_rd_rsp_mdata  out  MDATA  read response mdata, MSB cleared, common to both requesters
- u_rd_rsp_data  out  CACHE_WIDTH  read response data, broadcast to both requesters
- u_wr_req_addr  in  2*ADDR_LMT  per-requester write address
- u_wr_req_mdata  in  2*MDATA  per-requester write mdata
- u_wr_req_data  in  2*CACHE_WIDTH  per-requester write data
- u_wr_req_en  in  2  per-requester write request strobe
- u_wr_req_almostfull  out  2  per-requester write back-pressure
- u_wr_rsp0_valid, u_wr_rsp1_valid  out  2 each  routed write response valids
- u_wr_rsp0_mdata, u_wr_rsp1_mdata  out  MDATA each  write response mdata, MSB cleared
- rd_req_addr / rd_req_mdata / rd_req_en  out  ADDR_LMT / MDATA / 1  downstream read request, registered
- rd_req_almostfull  in  1  downstream read back-pressure
- rd_rsp_valid / rd_rsp_mdata / rd_rsp_data  in  1 / MDATA / CACHE_WIDTH  downstream read response
- wr_req_addr / wr_req_mdata / wr_req_data / wr_req_en  out  ADDR_LMT / MDATA / CACHE_WIDTH / 1  downstream write request, registered
- wr_req_almostfull  in  1  downstream write back-pressure
- wr_rsp0_valid / wr_rsp0_mdata / wr_rsp1_valid / wr_rsp1_mdata  in  1 / MDATA each  downstream write responses
- proto_err  out  2  sticky, bit i set when requester i strobes en while its almostfull is high

Behaviour:
- Reset (asynchronous): clears all hold registers, round-robin pointers (pointing at requester 1, so requester 0 wins first), outstanding counters, proto_err and all registered outputs.
- Response paths are combinational and are not cleared by reset. Responses arriving after reset are still routed by mdata MSB.
- Holding: one hold register per requester per channel.
  - u_*_req_almostfull[i] = hold_valid[i] | (outstanding[i] == MAX_OUTSTANDING).
  - An en with almostfull low loads the hold register at the next edge.
  - An en with almostfull high is dropped and sets proto_err[i].
- Grant, evaluated independently for the read and write channels each cycle:
  - Candidates are hold_valid requesters whose outstanding count is below the limit.
  - Grant only when downstream almostfull is low.
  - One candidate: grant it. Two candidates: grant the one not granted last, then update the pointer.
  - No candidate, or almostfull high: downstream en = 0 on the next cycle.
- Downstream request: the granted entry drives the registered outputs. en is high for exactly one cycle per grant. The hold register frees at the same edge.
  - Best-case latency: u en at cycle N -> hold at N+1 -> downstream en at N+2.
  - Per requester, at most one request every 2 cycles per channel.
- mdata tagging: downstream mdata = {requester ID, u_mdata[MDATA-2:0]}. The requester's MSB is ignored.
- Outstanding counters:
  - Read counter increments on read grant and decrements on a routed rd_rsp_valid.
  - Write counter increments on write grant. Decrement per routed write response: by 1, or by 2 when both write response ports target the same requester in one cycle.
  - Grant and response in the same cycle leave the count unchanged.
  - Counters saturate at 0 and never underflow.
- Response routing: rd_rsp_valid is steered to u_rd_rsp_valid[rd_rsp_mdata MSB]. wr_rsp0 and wr_rsp1 are each steered by their own MSB. When both are valid, both are delivered, even to the same requester.

Optional Feature:
- Macro: ARB_STRICT_PRIO_EN.
- Defined: fixed priority, requester 0 always wins over requester 1. The round-robin pointer logic is removed.
- Undefined: round-robin as described above.

Test Plan:
- Both requesters strobe a read in the same cycle (addr 0x10 and 0x20), downstream almostfull low -> downstream reads in consecutive grant cycles: 0x10 with mdata MSB 0 first, then 0x20 with MSB 1. Each almostfull is high until its request is granted.
- Downstream rd_req_almostfull held high for 5 cycles with both holds full -> no rd_req_en during that window. After release, grants alternate starting with requester 0.
- Read response with mdata 14'h2005 -> u_rd_rsp_valid = 2'b10, u_rd_rsp_mdata = 14'h0005. Requester 1 outstanding count decrements by 1.
- wr_rsp0 and wr_rsp1 both valid, MSBs 0 and 1 -> u_wr_rsp0_valid = 2'b01 and u_wr_rsp1_valid = 2'b10 in the same cycle. Both write counters decrement.
- Requester 0 issues 16 reads with no responses -> u_rd_req_almostfull[0] is high and requester 0 receives no further grants while requester 1 is still granted. One response re-enables requester 0.
- Requester 1 strobes en while almostfull is high -> proto_err = 2'b10, request dropped. Assert reset_n low mid-transfer -> all outputs and counters return to 0.
